// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan driver for an N-digit seven-segment display.
//
// Sits directly upstream of a hex-to-segment decoder. Each digit owns one slot
// of TICK_DIV clocks; the first DEAD clocks of every slot keep all digits off
// to suppress ghosting. Display data is double-buffered: loads land in a
// pending register and are promoted to the displayed (shadow) value only at
// the frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk50m      in   system clock, rising edge
//   rst         in   synchronous reset, active-high
//   value_i     in   4*NUM_DIGITS hex digits, [3:0] is digit 0
//   load        in   single-cycle strobe capturing value_i / blank_lz_i
//   blank_lz_i  in   leading-zero blanking enable for the loaded value
//   hex         out  nibble for the segment decoder
//   blank       out  high forces all segments off
//   digit_sel   out  active-low one-hot common-digit enable (all ones = off)
//   load_ack    out  one-cycle pulse when a loaded value becomes displayed
//   frame_done  out  one-cycle pulse at the end of the last digit slot
module seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DEAD       = 500
) (
  input  logic                    clk50m,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load,
  input  logic                    blank_lz_i,
  output logic [3:0]              hex,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Nibble k of a packed digit vector.
  function automatic logic [3:0] digit_of(input logic [VAL_W-1:0] v,
                                          input logic [IDX_W-1:0] k);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) == k) r = v[4*j +: 4];
    end
    return r;
  endfunction

  // Active-low enable with only digit k pulled low.
  function automatic logic [NUM_DIGITS-1:0] sel_of(input logic [IDX_W-1:0] k);
    logic [NUM_DIGITS-1:0] r;
    r = '1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) == k) r[j] = 1'b0;
    end
    return r;
  endfunction

  // Digit k is a leading zero when it and every more-significant digit are
  // zero. Digit 0 always stays lit so an all-zero value still shows "0".
  function automatic logic lz_blank(input logic [VAL_W-1:0] v,
                                    input logic             lz,
                                    input logic [IDX_W-1:0] k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IDX_W'(j) >= k) && (v[4*j +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    return lz && (k != '0) && upper_zero;
  endfunction

  // Scan state and buffers (stage 0)
  logic [CNT_W-1:0] cnt_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [VAL_W-1:0] shadow_val_p0;
  logic             shadow_lz_p0;
  logic [VAL_W-1:0] pend_val_p0;
  logic             pend_lz_p0;
  logic             pend_vld_p0;

  logic slot_end;
  logic frame_end;
  logic in_dead;

  assign slot_end  = (cnt_p0 == CNT_LAST);
  assign frame_end = slot_end && (idx_p0 == IDX_LAST);
  assign in_dead   = (cnt_p0 < CNT_DEAD);

  // Pending data needs no reset: pend_vld_p0 qualifies it, and a load that
  // coincides with rst is dropped because pend_vld_p0 is held clear.
  always_ff @(posedge clk50m) begin
    if (load) begin
      pend_val_p0 <= value_i;
      pend_lz_p0  <= blank_lz_i;
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt_p0        <= '0;
      idx_p0        <= '0;
      shadow_val_p0 <= '0;
      shadow_lz_p0  <= 1'b0;
      pend_vld_p0   <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end

      // A load landing exactly on the boundary bypasses pending entirely.
      if (frame_end && load) begin
        shadow_val_p0 <= value_i;
        shadow_lz_p0  <= blank_lz_i;
        pend_vld_p0   <= 1'b0;
      end else if (frame_end && pend_vld_p0) begin
        shadow_val_p0 <= pend_val_p0;
        shadow_lz_p0  <= pend_lz_p0;
        pend_vld_p0   <= 1'b0;
      end else if (load) begin
        pend_vld_p0   <= 1'b1;
      end
    end
  end

  // Output registers (stage 1): one cycle behind the scan state
  always_ff @(posedge clk50m) begin
    if (rst) begin
      hex        <= 4'h0;
      blank      <= 1'b1;
      digit_sel  <= '1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hex        <= digit_of(shadow_val_p0, idx_p0);
      frame_done <= frame_end;
      load_ack   <= frame_end && (load || pend_vld_p0);
      if (in_dead) begin
        digit_sel <= '1;
        blank     <= 1'b1;
      end else begin
        digit_sel <= sel_of(idx_p0);
        blank     <= lz_blank(shadow_val_p0, shadow_lz_p0, idx_p0);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

  localparam int N     = 4;
  localparam int TD    = 8;
  localparam int DD    = 2;
  localparam int FRAME = N * TD;

  logic        clk;
  logic        rst;
  logic [15:0] value_i;
  logic        load;
  logic        blank_lz_i;
  logic [3:0]  hex;
  logic        blank;
  logic [3:0]  digit_sel;
  logic        load_ack;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan #(.NUM_DIGITS(N), .TICK_DIV(TD), .DEAD(DD)) dut (
    .clk50m     (clk),
    .rst        (rst),
    .value_i    (value_i),
    .load       (load),
    .blank_lz_i (blank_lz_i),
    .hex        (hex),
    .blank      (blank),
    .digit_sel  (digit_sel),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the cycle position p since reset release determines the
  // slot and phase arithmetically; display data follows the double-buffer rules.
  int          p;
  logic [15:0] shadow, pend;
  logic        shadow_lz, pend_lz, pend_v;
  logic [3:0]  exp_hex, exp_sel;
  logic        exp_blank, exp_ack, exp_fd;

  int         m_slot, m_phase;
  logic       m_bnd, m_dead, m_lzb;
  logic [3:0] m_nib;

  always_comb begin
    m_phase = p % TD;
    m_slot  = (p / TD) % N;
    m_bnd   = (p % FRAME) == FRAME - 1;
    m_dead  = m_phase < DD;
    m_nib   = 4'(shadow >> (4 * m_slot));
    m_lzb   = shadow_lz && (m_slot != 0) && ((shadow >> (4 * m_slot)) == 16'h0);
  end

  always @(posedge clk) begin
    if (rst) begin
      p         <= 0;
      shadow    <= 16'h0;
      shadow_lz <= 1'b0;
      pend_v    <= 1'b0;
      exp_hex   <= 4'h0;
      exp_blank <= 1'b1;
      exp_sel   <= 4'hF;
      exp_ack   <= 1'b0;
      exp_fd    <= 1'b0;
    end else begin
      exp_hex   <= m_nib;
      exp_sel   <= m_dead ? 4'hF : ~(4'(1) << m_slot);
      exp_blank <= m_dead ? 1'b1 : m_lzb;
      exp_fd    <= m_bnd;
      exp_ack   <= m_bnd && (load || pend_v);
      if (m_bnd && load) begin
        shadow    <= value_i;
        shadow_lz <= blank_lz_i;
        pend_v    <= 1'b0;
      end else if (m_bnd && pend_v) begin
        shadow    <= pend;
        shadow_lz <= pend_lz;
        pend_v    <= 1'b0;
      end else if (load) begin
        pend    <= value_i;
        pend_lz <= blank_lz_i;
        pend_v  <= 1'b1;
      end
      p <= p + 1;
    end
  end

  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("hex", hex, exp_hex);
      chk("blank", blank, exp_blank);
      chk("digit_sel", digit_sel, exp_sel);
      chk("load_ack", load_ack, exp_ack);
      chk("frame_done", frame_done, exp_fd);
      chk("one_digit_on", ($countones(~digit_sel) <= 1), 1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sel", digit_sel, 4'hF);
    chk("rst_blank", blank, 1'b1);
    chk("rst_hex", hex, 4'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] v, input logic lz);
    value_i    = v;
    blank_lz_i = lz;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((p % FRAME) == ph) break;
    end
    chk("wait_phase_timeout", (k < 200), 1);
  endtask

  task automatic count_acks(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (load_ack) c++;
    end
  endtask

  initial begin
    int first_sel, first_fd, c;
    rst        = 1'b1;
    load       = 1'b0;
    value_i    = 16'h0;
    blank_lz_i = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Reset and first-frame timing
    @(negedge clk);
    do_reset();
    first_sel = -1;
    first_fd  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (first_sel < 0 && digit_sel == 4'b1110) first_sel = k;
      if (first_fd < 0 && frame_done) first_fd = k;
    end
    chk("first_sel_delay", first_sel, 3);
    chk("first_frame_done", first_fd, 32);

    // Basic scan: mid-frame load, one ack at the next boundary
    wait_phase(10);
    pulse(16'h1234, 1'b0);
    count_acks(64, c);
    chk("basic_ack_count", c, 1);

    // Tear-free update: last load before the boundary wins, single ack
    wait_phase(5);
    pulse(16'hAAAA, 1'b0);
    repeat (2) @(negedge clk);
    pulse(16'h5555, 1'b0);
    count_acks(40, c);
    chk("tear_ack_count", c, 1);
    repeat (40) @(negedge clk);

    // Load exactly on the boundary cycle
    wait_phase(FRAME - 1);
    pulse(16'h00F0, 1'b0);
    chk("coin_ack", load_ack, 1'b1);
    count_acks(40, c);
    chk("coin_no_more_ack", c, 0);

    // Leading-zero blanking
    wait_phase(3);
    pulse(16'h0040, 1'b1);
    count_acks(64, c);
    chk("lz_ack_count", c, 1);
    wait_phase(3);
    pulse(16'h0000, 1'b1);
    count_acks(64, c);
    chk("lz_zero_ack_count", c, 1);

    // Randomized loads at arbitrary phases
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 45)) @(negedge clk);
      pulse(16'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (70) @(negedge clk);

    // Reset with a pending load outstanding: no ack, all digits show 0
    wait_phase(8);
    pulse(16'h9876, 1'b1);
    repeat (3) @(negedge clk);
    do_reset();
    count_acks(70, c);
    chk("rst_pending_ack", c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
